// File: rtl/rsp_xswitch.sv
// Registered NI x NT response switch with per-output round-robin arbitration.
// Optional build macro XSW_PKT_LOCK_EN locks an output to one input for a whole packet.
module rsp_xswitch #(
    parameter int unsigned NI  = 5,
    parameter int unsigned NT  = 3,
    parameter int unsigned VDW = 37
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NI-1:0]     in_valid,
    input  logic [NI*NT-1:0]  in_req,
    input  logic [NI*VDW-1:0] in_data,
    input  logic [NI-1:0]     in_last,
    output logic [NI-1:0]     in_ready,
    output logic [NT-1:0]     out_valid,
    output logic [NT*VDW-1:0] out_data,
    output logic [NT-1:0]     out_last,
    input  logic [NT-1:0]     out_ready,
    output logic              err
);

    localparam int unsigned IW = (NI > 1) ? $clog2(NI) : 1;

    logic [NI-1:0]  legal;
    logic [NI-1:0]  drop;
    logic [NI-1:0]  cand     [NT];
    logic [NT-1:0]  gnt_vld;
    logic [IW-1:0]  gnt_idx  [NT];
    logic [VDW-1:0] gnt_data [NT];
    logic [NT-1:0]  gnt_last;
    logic [NT-1:0]  load;
    logic [NT-1:0]  accept;
    logic [NT-1:0]  ptr_upd;

    logic [IW-1:0]  ptr_q      [NT];
    logic [NT-1:0]  out_valid_q;
    logic [VDW-1:0] out_data_q [NT];
    logic [NT-1:0]  out_last_q;
    logic           err_q;
    logic           err_d;

`ifdef XSW_PKT_LOCK_EN
    logic [NT-1:0] lock_q;
    logic [NT-1:0] lock_d;
    logic [IW-1:0] owner_q [NT];
    logic [IW-1:0] owner_d [NT];
    logic          dst_chg;
`endif

    // Illegal (zero or multi-hot) requests are consumed and dropped.
    always_comb begin
        legal = '0;
        drop  = '0;
        for (int i = 0; i < int'(NI); i++) begin
            int cnt;
            cnt = 0;
            for (int t = 0; t < int'(NT); t++) begin
                cnt += int'(in_req[i*NT+t]);
            end
            legal[i] = (cnt == 1);
            drop[i]  = in_valid[i] & ~legal[i];
        end
    end

    always_comb begin
        for (int t = 0; t < int'(NT); t++) begin
            cand[t] = '0;
            for (int i = 0; i < int'(NI); i++) begin
`ifdef XSW_PKT_LOCK_EN
                cand[t][i] = in_valid[i] & legal[i] & in_req[i*NT+t] &
                             (~lock_q[t] | (owner_q[t] == IW'(i)));
`else
                cand[t][i] = in_valid[i] & legal[i] & in_req[i*NT+t];
`endif
            end
        end
    end

    // Round-robin search starting at ptr_q[t], wrapping at NI-1.
    always_comb begin
        gnt_vld = '0;
        for (int t = 0; t < int'(NT); t++) begin
            gnt_idx[t] = '0;
            for (int k = 0; k < int'(NI); k++) begin
                int idx;
                idx = int'(ptr_q[t]) + k;
                if (idx >= int'(NI)) begin
                    idx -= int'(NI);
                end
                if (!gnt_vld[t] && cand[t][idx]) begin
                    gnt_vld[t] = 1'b1;
                    gnt_idx[t] = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt_last = '0;
        for (int t = 0; t < int'(NT); t++) begin
            gnt_data[t] = '0;
            for (int i = 0; i < int'(NI); i++) begin
                if (gnt_idx[t] == IW'(i)) begin
                    gnt_data[t] = in_data[i*VDW +: VDW];
                    gnt_last[t] = in_last[i];
                end
            end
        end
    end

    assign load   = ~out_valid_q | out_ready;
    assign accept = gnt_vld & load;

`ifdef XSW_PKT_LOCK_EN
    assign ptr_upd = accept & gnt_last;
`else
    assign ptr_upd = accept;
`endif

    always_comb begin
        in_ready = drop;
        for (int t = 0; t < int'(NT); t++) begin
            for (int i = 0; i < int'(NI); i++) begin
                if (accept[t] && gnt_idx[t] == IW'(i)) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
    end

`ifdef XSW_PKT_LOCK_EN
    // An accepted beat from a lock owner on another output means it changed
    // destination mid-packet: flag it and release the stale lock.
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        dst_chg = 1'b0;
        for (int t = 0; t < int'(NT); t++) begin
            if (accept[t]) begin
                lock_d[t]  = ~gnt_last[t];
                owner_d[t] = gnt_idx[t];
            end
        end
        for (int t = 0; t < int'(NT); t++) begin
            for (int t2 = 0; t2 < int'(NT); t2++) begin
                if (t2 != t && accept[t] && lock_q[t2] && owner_q[t2] == gnt_idx[t]) begin
                    dst_chg    = 1'b1;
                    lock_d[t2] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= '0;
            for (int t = 0; t < int'(NT); t++) begin
                owner_q[t] <= '0;
            end
        end else begin
            lock_q <= lock_d;
            for (int t = 0; t < int'(NT); t++) begin
                owner_q[t] <= owner_d[t];
            end
        end
    end

    assign err_d = err_q | (|drop) | dst_chg;
`else
    assign err_d = err_q | (|drop);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_last_q  <= '0;
            err_q       <= 1'b0;
            for (int t = 0; t < int'(NT); t++) begin
                out_data_q[t] <= '0;
                ptr_q[t]      <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int t = 0; t < int'(NT); t++) begin
                if (accept[t]) begin
                    out_valid_q[t] <= 1'b1;
                    out_data_q[t]  <= gnt_data[t];
                    out_last_q[t]  <= gnt_last[t];
                end else if (out_ready[t]) begin
                    out_valid_q[t] <= 1'b0;
                end
                if (ptr_upd[t]) begin
                    ptr_q[t] <= (gnt_idx[t] == IW'(NI - 1)) ? '0 : gnt_idx[t] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int t = 0; t < int'(NT); t++) begin
            out_data[t*VDW +: VDW] = out_data_q[t];
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule
